// File: rtl/ct_bist_pkg.sv
// ----------------------------------------------------------------------------
// ct_bist_pkg
// Shared types and constants for the CT built-in self-test generator:
//   - bist_state_e : run-control state of ct_bist_gen
//   - ct_vec_t     : one stimulus vector laid out exactly as the low 29 bits
//                    of the LFSR state (opcode in the top field, in_n0 lowest)
//   - width constants and the LFSR / MISR tap masks
//   - lfsr_step / lfsr_seed_fix / lfsr_to_vec helpers
// ----------------------------------------------------------------------------
package ct_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 9;
  localparam int LFSR_W    = 32;
  localparam int SIG_W     = 16;
  localparam int CNT_W     = 16;
  localparam int SETTLE_W  = 4;
  localparam int VEC_W     = OPCODE_W + 6 * OPERAND_W;

  // x^32 + x^22 + x^2 + x + 1 : feedback taps at state bits 31, 21, 1, 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  // x^16 + x^15 + x^13 + x^4 + 1 : feedback taps at signature bits 15, 14, 12, 3
  localparam logic [SIG_W-1:0]  MISR_TAPS = 16'hD008;

  // Member order puts opcode in the MSBs so a cast of s[28:0] lands each
  // field on its LFSR slice.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] in_n5;
    logic [OPERAND_W-1:0] in_n4;
    logic [OPERAND_W-1:0] in_n3;
    logic [OPERAND_W-1:0] in_n2;
    logic [OPERAND_W-1:0] in_n1;
    logic [OPERAND_W-1:0] in_n0;
  } ct_vec_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero Fibonacci LFSR locks up, so a zero seed is promoted to 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

  function automatic ct_vec_t lfsr_to_vec(input logic [LFSR_W-1:0] s);
    return ct_vec_t'(s[VEC_W-1:0]);
  endfunction

endpackage

// File: rtl/ct_misr.sv
// ----------------------------------------------------------------------------
// ct_misr
// SIG_W-bit multiple-input signature register compacting the CT result.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (signature <= seed)
//   load      : reseed the signature from `seed` (run start)
//   en        : fold `din` into the signature on this edge
//   seed      : reseed / reset value
//   din       : RESULT_W-bit response, zero-extended into the low bits
//   sig       : current signature (registered)
//   sig_next  : value the signature takes if `en` is asserted this cycle
// ----------------------------------------------------------------------------
module ct_misr
  import ct_bist_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [SIG_W-1:0]    seed,
  input  logic [RESULT_W-1:0] din,
  output logic [SIG_W-1:0]    sig,
  output logic [SIG_W-1:0]    sig_next
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fold;

  always_comb begin
    fold = {sig_q[SIG_W-2:0], ^(sig_q & MISR_TAPS)}
           ^ {{(SIG_W-RESULT_W){1'b0}}, din};
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = fold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig      = sig_q;
  assign sig_next = fold;

endmodule

// File: rtl/ct_bist_gen.sv
// ----------------------------------------------------------------------------
// ct_bist_gen
// Self-test stimulus generator and response compactor for the CT opcode
// calculator. A 32-bit LFSR produces one vector per period of
// SETTLE_CYCLES+1 cycles; on the last edge of each period the CT response is
// folded into a 16-bit MISR and the next vector is launched. After
// NUM_VECTORS captures the run ends and the signature is compared with
// GOLDEN_SIG.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : run request, honoured in IDLE or DONE
//   busy / done       : run in progress / run finished (until next start/rst)
//   pass              : signature matched GOLDEN_SIG, only while done
//   signature         : current MISR value
//   opcode, in_n0..5  : registered stimulus to CT
//   out_n             : combinational CT response
// ----------------------------------------------------------------------------
module ct_bist_gen
  import ct_bist_pkg::*;
#(
  parameter int               NUM_VECTORS   = 256,
  parameter int               SETTLE_CYCLES = 1,
  parameter logic [31:0]      LFSR_SEED     = 32'h0000_0001,
  parameter logic [15:0]      MISR_SEED     = 16'h0000,
  parameter logic [15:0]      GOLDEN_SIG    = 16'h0000
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [OPERAND_W-1:0] in_n0,
  output logic [OPERAND_W-1:0] in_n1,
  output logic [OPERAND_W-1:0] in_n2,
  output logic [OPERAND_W-1:0] in_n3,
  output logic [OPERAND_W-1:0] in_n4,
  output logic [OPERAND_W-1:0] in_n5,
  input  logic [RESULT_W-1:0]  out_n
);

  localparam logic [LFSR_W-1:0]   SEED_FIX    = lfsr_seed_fix(LFSR_SEED);
  localparam logic [CNT_W-1:0]    LAST_IDX    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

  bist_state_e          state_q,  state_d;
  logic [LFSR_W-1:0]    lfsr_q,   lfsr_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  ct_vec_t              vec_q,    vec_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic                 pass_q,   pass_d;

  logic                 start_acc;
  logic                 capture;
  logic                 last_cap;
  logic [LFSR_W-1:0]    lfsr_nxt;
  logic [SIG_W-1:0]     sig_now;
  logic [SIG_W-1:0]     sig_next;

  // capture marks the last edge of the current vector's hold window; the
  // response is sampled and the next vector launched on that same edge.
  assign start_acc = start && (state_q != RUN);
  assign capture   = (state_q == RUN) && (settle_q == SETTLE_LAST);
  assign last_cap  = capture && (cnt_q == LAST_IDX);
  assign lfsr_nxt  = lfsr_step(lfsr_q);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          lfsr_d   = SEED_FIX;
          cnt_d    = '0;
          settle_d = '0;
          vec_d    = lfsr_to_vec(SEED_FIX);
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
        end
      end

      RUN: begin
        if (capture) begin
          lfsr_d   = lfsr_nxt;
          settle_d = '0;
          if (last_cap) begin
            // Final vector stays on the pins; pass is judged on the
            // signature this edge produces.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_next == GOLDEN_SIG);
          end else begin
            cnt_d = cnt_q + 1'b1;
            vec_d = lfsr_to_vec(lfsr_nxt);
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_FIX;
      cnt_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  ct_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc),
    .en       (capture),
    .seed     (MISR_SEED),
    .din      (out_n),
    .sig      (sig_now),
    .sig_next (sig_next)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_now;
  assign opcode    = vec_q.opcode;
  assign in_n0     = vec_q.in_n0;
  assign in_n1     = vec_q.in_n1;
  assign in_n2     = vec_q.in_n2;
  assign in_n3     = vec_q.in_n3;
  assign in_n4     = vec_q.in_n4;
  assign in_n5     = vec_q.in_n5;

endmodule

// File: tb/tb_ct_bist_gen.sv
// ----------------------------------------------------------------------------
// tb_ct_bist_gen
// Bench for ct_bist_gen. Instance A runs 4 vectors with a 3-cycle period
// against a stand-in CT response salted per run. Instances B and C run
// 2 single-cycle vectors with out_n tied to 9'h1FF and a zero LFSR seed;
// they differ only in the golden signature.
// ----------------------------------------------------------------------------
module tb_ct_bist_gen;

  localparam int          NV_A   = 4;
  localparam int          ST_A   = 2;
  localparam int          P_A    = ST_A + 1;
  localparam logic [15:0] GOLD_A = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic [8:0] salt;
  logic [8:0] ones = 9'h1FF;

  logic busy_a, done_a, pass_a;
  logic [15:0] sig_a;
  logic [4:0] op_a;
  logic [3:0] a0, a1, a2, a3, a4, a5;
  logic [8:0] out_a;

  logic busy_b, done_b, pass_b;
  logic [15:0] sig_b;
  logic [4:0] op_b;
  logic [3:0] b0, b1, b2, b3, b4, b5;

  logic busy_c, done_c, pass_c;
  logic [15:0] sig_c;
  logic [4:0] op_c;
  logic [3:0] c0, c1, c2, c3, c4, c5;

  int total = 0;
  int bad   = 0;

  // Stand-in for CT: any fixed combinational function of the vector will do.
  function automatic logic [8:0] ct_resp(input logic [28:0] v);
    int acc;
    acc = 13 * int'(v[28:24]) + int'(v[3:0]) + 2 * int'(v[7:4]) + 3 * int'(v[11:8])
          + 5 * int'(v[15:12]) + 7 * int'(v[19:16]) + 11 * int'(v[23:20]);
    return acc[8:0];
  endfunction

  function automatic logic [31:0] m_lfsr(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [8:0] r);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {7'b0, r};
  endfunction

  assign out_a = ct_resp({op_a, a5, a4, a3, a2, a1, a0}) ^ salt;

  ct_bist_gen #(.NUM_VECTORS(NV_A), .SETTLE_CYCLES(ST_A), .LFSR_SEED(32'h1),
                .MISR_SEED(16'h0), .GOLDEN_SIG(GOLD_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .opcode(op_a), .in_n0(a0), .in_n1(a1), .in_n2(a2), .in_n3(a3),
    .in_n4(a4), .in_n5(a5), .out_n(out_a));

  ct_bist_gen #(.NUM_VECTORS(2), .SETTLE_CYCLES(0), .LFSR_SEED(32'h0),
                .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0200)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .opcode(op_b), .in_n0(b0), .in_n1(b1), .in_n2(b2), .in_n3(b3),
    .in_n4(b4), .in_n5(b5), .out_n(ones));

  ct_bist_gen #(.NUM_VECTORS(2), .SETTLE_CYCLES(0), .LFSR_SEED(32'h0),
                .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0201)) u_c (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .opcode(op_c), .in_n0(c0), .in_n1(c1), .in_n2(c2), .in_n3(c3),
    .in_n4(c4), .in_n5(c5), .out_n(ones));

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; salt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if ({busy_a, done_a, pass_a} !== 3'b000) begin bad++;
      $display("FAIL reset_ctrl_a: got %b want 000", {busy_a, done_a, pass_a}); end
    total++; if (sig_a !== 16'h0000) begin bad++;
      $display("FAIL reset_sig_a: got %h want 0000", sig_a); end
    total++; if ({op_a, a5, a4, a3, a2, a1, a0} !== 29'h0) begin bad++;
      $display("FAIL reset_stim_a: got %h want 0", {op_a, a5, a4, a3, a2, a1, a0}); end
    total++; if ({busy_b, done_b, pass_b, busy_c, done_c, pass_c} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl_bc: got %b want 000000",
               {busy_b, done_b, pass_b, busy_c, done_c, pass_c}); end
    total++; if ({sig_b, op_b, b5, b4, b3, b2, b1, b0} !== 45'h0) begin bad++;
      $display("FAIL reset_out_b: got %h want 0", {sig_b, op_b, b5, b4, b3, b2, b1, b0}); end
  endtask

  task automatic test_vectors();
    int i;
    salt = 9'h000;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    total++; if ({op_a, a5, a4, a3, a2, a1, a0} !== 29'h1) begin bad++;
      $display("FAIL vec0: got %h want 1", {op_a, a5, a4, a3, a2, a1, a0}); end
    total++; if (busy_a !== 1'b1) begin bad++;
      $display("FAIL busy_rise: got %b want 1", busy_a); end
    repeat (P_A) @(negedge clk);
    total++; if (a0 !== 4'd3 || op_a !== 5'd0) begin bad++;
      $display("FAIL vec1: got in_n0=%h opcode=%h want 3 0", a0, op_a); end
    i = 0;
    while (i < 40 && done_a !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    total++; if (done_a !== 1'b1) begin bad++;
      $display("FAIL vec_run_timeout: got done=%b want 1", done_a); end
  endtask

  task automatic test_misr_arith();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    total++; if ({op_b, b5, b4, b3, b2, b1, b0} !== 29'h1) begin bad++;
      $display("FAIL zero_seed_vec0: got %h want 1", {op_b, b5, b4, b3, b2, b1, b0}); end
    total++; if (sig_b !== 16'h0000 || busy_b !== 1'b1 || pass_b !== 1'b0) begin bad++;
      $display("FAIL misr_t0: got sig=%h busy=%b pass=%b want 0000 1 0", sig_b, busy_b, pass_b); end
    @(negedge clk);
    total++; if (sig_b !== 16'h01FF) begin bad++;
      $display("FAIL misr_v0: got %h want 01ff", sig_b); end
    total++; if (busy_b !== 1'b1 || done_b !== 1'b0 || b0 !== 4'd3) begin bad++;
      $display("FAIL misr_mid: got busy=%b done=%b in_n0=%h want 1 0 3", busy_b, done_b, b0); end
    @(negedge clk);
    total++; if (sig_b !== 16'h0200) begin bad++;
      $display("FAIL misr_done_sig: got %h want 0200", sig_b); end
    total++; if ({busy_b, done_b, pass_b} !== 3'b011) begin bad++;
      $display("FAIL misr_pass: got busy/done/pass=%b want 011", {busy_b, done_b, pass_b}); end
    total++; if ({done_c, pass_c} !== 2'b10 || sig_c !== 16'h0200) begin bad++;
      $display("FAIL misr_nopass: got done/pass=%b sig=%h want 10 0200", {done_c, pass_c}, sig_c); end
  endtask

  // One complete run of instance A, checked cycle by cycle against the model.
  task automatic test_run(input logic [8:0] s_in, input bit mid_start, output logic [15:0] sig_out);
    logic [31:0] v [NV_A];
    logic [15:0] m [NV_A+1];
    logic [28:0] stim;
    int pt;
    salt = s_in;
    v[0] = 32'h1;
    for (int k = 1; k < NV_A; k++) v[k] = m_lfsr(v[k-1]);
    m[0] = 16'h0;
    for (int k = 0; k < NV_A; k++) m[k+1] = m_misr(m[k], ct_resp(v[k][28:0]) ^ s_in);
    pt = mid_start ? int'($urandom_range(NV_A * P_A - 1, 1)) : -1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int t = 0; t <= NV_A * P_A; t++) begin
      stim = {op_a, a5, a4, a3, a2, a1, a0};
      if (t < NV_A * P_A) begin
        total++; if ({busy_a, done_a, pass_a} !== 3'b100) begin bad++;
          $display("FAIL run_ctrl t=%0d: got %b want 100", t, {busy_a, done_a, pass_a}); end
        total++; if (stim !== v[t / P_A][28:0]) begin bad++;
          $display("FAIL run_vec t=%0d: got %h want %h", t, stim, v[t / P_A][28:0]); end
        total++; if (sig_a !== m[t / P_A]) begin bad++;
          $display("FAIL run_sig t=%0d: got %h want %h", t, sig_a, m[t / P_A]); end
      end else begin
        total++; if ({busy_a, done_a} !== 2'b01) begin bad++;
          $display("FAIL run_end: got busy/done=%b want 01", {busy_a, done_a}); end
        total++; if (sig_a !== m[NV_A]) begin bad++;
          $display("FAIL run_final_sig: got %h want %h", sig_a, m[NV_A]); end
        total++; if (pass_a !== (m[NV_A] == GOLD_A)) begin bad++;
          $display("FAIL run_pass: got %b want %b", pass_a, (m[NV_A] == GOLD_A)); end
      end
      if (t == pt) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    total++; if (done_a !== 1'b1 || sig_a !== m[NV_A]) begin bad++;
      $display("FAIL run_hold: got done=%b sig=%h want 1 %h", done_a, sig_a, m[NV_A]); end
    sig_out = sig_a;
  endtask

  task automatic test_random_runs();
    logic [15:0] s;
    for (int r = 0; r < 5; r++) begin
      test_run(9'($urandom), 1'($urandom), s);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  task automatic test_rerun();
    logic [15:0] s1, s2;
    logic [8:0] sv;
    sv = 9'($urandom);
    test_run(sv, 1'b0, s1);
    test_run(sv, 1'b1, s2);
    total++; if (s2 !== s1) begin bad++;
      $display("FAIL rerun_sig: got %h want %h", s2, s1); end
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    salt = 9'($urandom);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (2 * P_A + 1) @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++;
      $display("FAIL abort_pre_busy: got %b want 1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy_a, done_a, pass_a} !== 3'b000 || sig_a !== 16'h0000) begin bad++;
      $display("FAIL abort_ctrl: got %b sig=%h want 000 0000", {busy_a, done_a, pass_a}, sig_a); end
    total++; if ({op_a, a5, a4, a3, a2, a1, a0} !== 29'h0) begin bad++;
      $display("FAIL abort_stim: got %h want 0", {op_a, a5, a4, a3, a2, a1, a0}); end
    saw_done = 1'b0;
    repeat (4 * NV_A * P_A) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++;
      $display("FAIL abort_no_done: got activity=%b want 0", saw_done); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_misr_arith();
    test_random_runs();
    test_rerun();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
